// File: rtl/code_frame_pkg.sv
// Shared constants and state encoding for the code_frame_tx transmitter.
package code_frame_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_MAX   = 5'd19;
  localparam logic [CODE_W-1:0] BLANK_CODE = 5'b00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/code_frame_tx_parity_gen.sv
// Combinational parity generator for a 5-bit code: even (XOR) or odd (XNOR).
module parity_gen
  import code_frame_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [CODE_W-1:0] data,
  output logic              parity
);

  assign parity = (^data) ^ ODD_PARITY;

endmodule

// File: rtl/code_frame_tx.sv
// 5-bit code + parity frame transmitter: HOLD_CYCLES of code, GAP_CYCLES of blank.
// Optional macro FAULT_INJ_EN adds inj_fault to invert parity of a chosen frame.
module code_frame_tx
  import code_frame_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          ODD_PARITY  = 1'b0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
`ifdef FAULT_INJ_EN
  input  logic              inj_fault,
`endif
  output logic              b1,
  output logic              b2,
  output logic              b3,
  output logic              b4,
  output logic              b5,
  output logic              b_par,
  output logic              frame_active,
  output logic              reject,
  output logic [CNT_W-1:0]  sent_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  // Blank frames carry deliberately wrong parity so the display stays dark.
  localparam logic BLANK_PAR = ~ODD_PARITY;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                par_q, par_d;
  logic                active_q, active_d;
  logic                reject_q, reject_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                code_par;
  logic                flip;

  parity_gen #(.ODD_PARITY(ODD_PARITY)) u_parity (
    .data   (in_code),
    .parity (code_par)
  );

`ifdef FAULT_INJ_EN
  assign flip = inj_fault;
`else
  assign flip = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    code_d   = code_q;
    par_d    = par_q;
    active_d = active_q;
    reject_d = 1'b0;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          if (in_code <= CODE_MAX) begin
            state_d  = HOLD;
            hold_d   = '0;
            code_d   = in_code;
            par_d    = code_par ^ flip;
            active_d = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d  = GAP;
          gap_d    = '0;
          code_d   = BLANK_CODE;
          par_d    = BLANK_PAR;
          active_d = 1'b0;
          count_d  = count_q + CNT_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      gap_q    <= '0;
      code_q   <= BLANK_CODE;
      par_q    <= BLANK_PAR;
      active_q <= 1'b0;
      reject_q <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      par_q    <= par_d;
      active_q <= active_d;
      reject_q <= reject_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
    end
  end

  assign {b1, b2, b3, b4, b5} = code_q;
  assign b_par        = par_q;
  assign frame_active = active_q;
  assign reject       = reject_q;
  assign in_ready     = ready_q;
  assign sent_count   = count_q;

endmodule

// File: tb/tb_code_frame_tx.sv
// Scoreboard bench for code_frame_tx: driver pushes expected frames/rejects, monitor pops and checks.
module tb_code_frame_tx;
  import code_frame_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int CW   = 2;
  localparam bit ODD  = 1'b0;
`ifdef FAULT_INJ_EN
  localparam bit HAS_INJ = 1'b1;
`else
  localparam bit HAS_INJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          inj_fault = 1'b0;
  logic [4:0]    in_code = '0;
  logic          in_ready, b1, b2, b3, b4, b5, b_par, frame_active, reject;
  logic [CW-1:0] sent_count;
  logic [4:0]    b_bus;

  assign b_bus = {b1, b2, b3, b4, b5};

  always #5 clk = ~clk;

  code_frame_tx #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ODD_PARITY(ODD), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
`ifdef FAULT_INJ_EN
    .inj_fault    (inj_fault),
`endif
    .b1           (b1),
    .b2           (b2),
    .b3           (b3),
    .b4           (b4),
    .b5           (b5),
    .b_par        (b_par),
    .frame_active (frame_active),
    .reject       (reject),
    .sent_count   (sent_count)
  );

  typedef struct {
    logic [4:0] code;
    logic       par;
  } frame_t;

  frame_t frame_q[$];
  frame_t cur;
  int     rej_pend  = 0;
  int     hold_run  = 0;
  int     gap_run   = 0;
  int     exp_count = 0;
  int     cyc       = 0;
  bit     mon_en    = 1'b0;
  int     n_checks  = 0;
  int     n_fail    = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference parity from the count of ones, independent of any XOR tree.
  function automatic logic ref_par(logic [4:0] c, logic inj);
    logic odd_ones;
    odd_ones = (($countones(c) % 2) == 1);
    return odd_ones ^ ODD ^ (inj & HAS_INJ);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mon_en) begin
      if (reject) begin
        check("reject_expected", (rej_pend > 0), 1);
        if (rej_pend > 0) rej_pend--;
        check("ready_on_reject", in_ready, 1);
      end
      if (frame_active) begin
        if (hold_run == 0) begin
          check("frame_expected", (frame_q.size() > 0), 1);
          if (frame_q.size() > 0) cur = frame_q.pop_front();
        end
        check("frame_code", b_bus, cur.code);
        check("frame_par", b_par, cur.par);
        check("ready_in_hold", in_ready, 0);
        hold_run++;
        gap_run = 0;
      end else begin
        if (hold_run > 0) begin
          check("hold_len", hold_run, HOLD);
          exp_count = (exp_count + 1) % (1 << CW);
          hold_run  = 0;
          gap_run   = 0;
        end
        check("blank_code", b_bus, 0);
        check("blank_par", b_par, !ODD);
        if (!in_ready) gap_run++;
        else if (gap_run > 0) begin
          check("gap_len", gap_run, GAP);
          gap_run = 0;
        end
      end
      check("sent_count", sent_count, exp_count);
    end
  end

  // Caller is at a falling edge (or time 0); reset is applied on the next rising edge.
  task automatic apply_reset();
    mon_en   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame_q.delete();
    rej_pend  = 0;
    hold_run  = 0;
    gap_run   = 0;
    exp_count = 0;
    check("rst_ready", in_ready, 1);
    check("rst_active", frame_active, 0);
    check("rst_reject", reject, 0);
    check("rst_count", sent_count, 0);
    check("rst_code", b_bus, 0);
    check("rst_par", b_par, !ODD);
    mon_en = 1'b1;
  endtask

  task automatic send(logic [4:0] c, logic inj);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", (t < 50), 1);
    in_valid  = 1'b1;
    in_code   = c;
    inj_fault = inj;
    if (c <= 5'd19) frame_q.push_back('{code: c, par: ref_par(c, inj)});
    else rej_pend++;
    @(negedge clk);
    in_valid  = 1'b0;
    in_code   = 5'($urandom_range(0, 31));
    inj_fault = 1'($urandom_range(0, 1));
  endtask

  // in_valid held high with code 5; in_code scrambled while the block is busy.
  task automatic stream(int n);
    int last = 0;
    in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        in_code = 5'($urandom_range(0, 31));
        @(negedge clk);
        t++;
      end
      check("stream_timeout", (t < 50), 1);
      in_code   = 5'd5;
      inj_fault = 1'b0;
      frame_q.push_back('{code: 5'd5, par: ref_par(5'd5, 1'b0)});
      if (k > 0) check("stream_spacing", cyc - last, HOLD + GAP + 1);
      last = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    apply_reset();
    repeat (3) @(negedge clk);
    check("idle_ready", in_ready, 1);
    check("idle_code", b_bus, 0);
    check("idle_par", b_par, !ODD);

    send(5'd7, 1'b0);
    send(5'd19, 1'b0);
    send(5'd20, 1'b0);
    send(5'd31, 1'b0);
    send(5'd16, 1'b0);
    send(5'd18, 1'b0);
    stream(3);

    send(5'd12, 1'b0);
    @(negedge clk);
    apply_reset();
    send(5'd9, 1'b0);
`ifdef FAULT_INJ_EN
    send(5'd3, 1'b1);
`endif
    send(5'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      send(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    t = 0;
    while ((frame_q.size() > 0 || !in_ready || frame_active) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain_timeout", (t < 100), 1);
    check("frames_left", frame_q.size(), 0);
    check("rejects_left", rej_pend, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
